// File: rtl/mips_pkg.sv
// Shared MIPS constants for the divide sequencer and the pipeline stall logic.
//   div_state_e : divider FSM encoding (IDLE=0, PREP=1, ITER=2, FIX=3, DONE=4)
//   DIV_WIDTH   : operand width handled by the divider
//   DIV_LAT     : clocks from accepted start to the done pulse
package mips_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_LAT   = 34;
endpackage

// File: rtl/Sub.sv
// 32-bit subtractor shared with the ALU datapath.
//   a, b : operands          bin : borrow in
//   diff : a - b - bin       CF  : borrow out (unsigned a < b + bin)
//   OF   : signed overflow of the subtraction
module Sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic [31:0] diff,
  output logic        CF,
  output logic        OF
);
  assign {CF, diff} = {1'b0, a} - {1'b0, b} - {32'b0, bin};
  assign OF = (a[31] ^ b[31]) & (a[31] ^ diff[31]);
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller: restoring division, one quotient bit per
// clock, using the shared Sub unit as the trial subtractor.
//   clk, rst        : clock, async active-high reset
//   start           : request, accepted only in IDLE or DONE
//   is_signed       : 1 = DIV, 0 = DIVU (latched with start)
//   dividend/divisor: operands (latched with start)
//   busy            : high in PREP, ITER, FIX
//   done            : one-cycle pulse in DONE
//   quo / rem       : LO / HI results, held until the next result is written
//   div_by_zero     : divisor was zero for the last operation
module div_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] dvd_q, dvs_q, dmag_q, r_q, q_q, quo_q, rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sgn_q, dbz_q, dbz_out_q, qneg_q, rneg_q;

  logic [WIDTH-1:0] r_sh, sub_diff, quo_fix, rem_fix;
  logic             sub_cf, sub_of_unused, accept;

  // Trial subtraction of |divisor| from the shifted partial remainder.
  assign r_sh = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  Sub u_sub (
    .a    (r_sh),
    .b    (dmag_q),
    .bin  (1'b0),
    .diff (sub_diff),
    .CF   (sub_cf),
    .OF   (sub_of_unused)
  );

  // A bit shifted out of R means R' exceeds 32 bits, so it is always >= divisor.
  assign accept = r_q[WIDTH-1] | ~sub_cf;

  assign quo_fix = dbz_q ? '1    : (qneg_q ? WIDTH'(0) - q_q : q_q);
  assign rem_fix = dbz_q ? dvd_q : (rneg_q ? WIDTH'(0) - r_q : r_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: begin
        busy    = 1'b1;
        state_d = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? PREP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      dmag_q    <= '0;
      r_q       <= '0;
      q_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      dbz_q     <= 1'b0;
      dbz_out_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          dvd_q <= dividend;
          dvs_q <= divisor;
          sgn_q <= is_signed;
          dbz_q <= (divisor == '0);
        end
        PREP: begin
          qneg_q <= sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          rneg_q <= sgn_q & dvd_q[WIDTH-1];
          dmag_q <= (sgn_q & dvs_q[WIDTH-1]) ? WIDTH'(0) - dvs_q : dvs_q;
          q_q    <= (sgn_q & dvd_q[WIDTH-1]) ? WIDTH'(0) - dvd_q : dvd_q;
          r_q    <= '0;
          cnt_q  <= '0;
        end
        ITER: begin
          r_q   <= accept ? sub_diff : r_sh;
          q_q   <= {q_q[WIDTH-2:0], accept};
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          quo_q     <= quo_fix;
          rem_q     <= rem_fix;
          dbz_out_q <= dbz_q;
        end
        default: ;
      endcase
    end
  end

  assign quo         = quo_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quo, rem;

  int n_checks = 0;
  int n_pass   = 0;

  div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quo(quo), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start; returns #1 after the accepting edge.
  task automatic launch(input bit s, input logic [31:0] dd, input logic [31:0] dv);
    @(negedge clk);
    is_signed = s; dividend = dd; divisor = dv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done (bounded); records whether busy held throughout.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quo, rem} !== 67'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b quo=%h rem=%h, want all 0",
               busy, done, div_by_zero, quo, rem);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_divu_basic;
    int lat; bit bok;
    launch(1'b0, 32'd100, 32'd7);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 34) $display("FAIL divu_latency: got %0d want 34", lat); else n_pass++;
    n_checks++;
    if (!bok) $display("FAIL divu_busy_held: busy dropped before done, want high"); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL divu_busy_at_done: got %b want 0", busy); else n_pass++;
    n_checks++;
    if ({quo, rem, div_by_zero} !== {32'd14, 32'd2, 1'b0})
      $display("FAIL divu_100_7: got quo=%h rem=%h dbz=%b want 0000000e 00000002 0", quo, rem, div_by_zero);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL done_pulse_width: got done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_signed;
    int lat; bit bok;
    launch(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bok);
    n_checks++;
    if ({quo, rem} !== {32'hFFFFFFFD, 32'hFFFFFFFF})
      $display("FAIL div_m7_2: got quo=%h rem=%h want fffffffd ffffffff", quo, rem);
    else n_pass++;
    launch(1'b0, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bok);
    n_checks++;
    if ({quo, rem} !== {32'h7FFFFFFC, 32'h00000001})
      $display("FAIL divu_fff9_2: got quo=%h rem=%h want 7ffffffc 00000001", quo, rem);
    else n_pass++;
  endtask

  task automatic test_boundaries;
    int lat; bit bok;
    launch(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bok);
    n_checks++;
    if ({quo, rem, div_by_zero} !== {32'h80000000, 32'h0, 1'b0})
      $display("FAIL div_overflow: got quo=%h rem=%h dbz=%b want 80000000 00000000 0", quo, rem, div_by_zero);
    else n_pass++;
    launch(1'b0, 32'hFFFFFFFF, 32'd1);
    wait_done(lat, bok);
    n_checks++;
    if ({quo, rem} !== {32'hFFFFFFFF, 32'h0})
      $display("FAIL divu_max_1: got quo=%h rem=%h want ffffffff 00000000", quo, rem);
    else n_pass++;
  endtask

  task automatic test_div_zero;
    int lat; bit bok;
    for (int s = 0; s < 2; s++) begin
      launch(s[0], 32'h12345678, 32'd0);
      wait_done(lat, bok);
      n_checks++;
      if (lat !== 34) $display("FAIL dbz_latency_s%0d: got %0d want 34", s, lat); else n_pass++;
      n_checks++;
      if ({quo, rem, div_by_zero} !== {32'hFFFFFFFF, 32'h12345678, 1'b1})
        $display("FAIL dbz_result_s%0d: got quo=%h rem=%h dbz=%b want ffffffff 12345678 1",
                 s, quo, rem, div_by_zero);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    launch(1'b0, 32'd1000, 32'd10);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (lat == 10) begin start = 1'b1; dividend = 32'd5; divisor = 32'd5; end
      if (lat == 11) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 34) $display("FAIL ignore_start_latency: got %0d want 34", lat); else n_pass++;
    n_checks++;
    if ({quo, rem, div_by_zero} !== {32'd100, 32'd0, 1'b0})
      $display("FAIL ignore_start_result: got quo=%h rem=%h dbz=%b want 00000064 00000000 0", quo, rem, div_by_zero);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat; bit bok;
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    // Second operation's operands presented while the first is busy; start stays high.
    is_signed = 1'b1; dividend = 32'hFFFFFF9C; divisor = 32'd7;
    wait_done(lat, bok);
    n_checks++;
    if ({lat, quo, rem} !== {32'd34, 32'd16, 32'd2})
      $display("FAIL b2b_first: got lat=%0d quo=%h rem=%h want 34 00000010 00000002", lat, quo, rem);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b10) $display("FAIL b2b_no_idle: got busy=%b done=%b want 1 0", busy, done);
    else n_pass++;
    start = 1'b0;
    wait_done(lat, bok);
    n_checks++;
    if ({lat, quo, rem} !== {32'd34, 32'hFFFFFFF2, 32'hFFFFFFFE})
      $display("FAIL b2b_second: got lat=%0d quo=%h rem=%h want 34 fffffff2 fffffffe", lat, quo, rem);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat; bit bok; bit saw_done;
    launch(1'b0, 32'd999, 32'd4);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero, quo, rem} !== 67'd0)
      $display("FAIL reset_mid_outputs: got busy=%b done=%b dbz=%b quo=%h rem=%h, want all 0",
               busy, done, div_by_zero, quo, rem);
    else n_pass++;
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) $display("FAIL reset_mid_no_done: got done pulse, want none"); else n_pass++;
    launch(1'b0, 32'd77, 32'd5);
    wait_done(lat, bok);
    n_checks++;
    if ({lat, quo, rem} !== {32'd34, 32'd15, 32'd2})
      $display("FAIL reset_mid_fresh: got lat=%0d quo=%h rem=%h want 34 0000000f 00000002", lat, quo, rem);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_signed;
    test_boundaries;
    test_div_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
